// File: rtl/io_pkg.sv
// Shared address map, STATUS layout and display state encoding for the
// memory-mapped I/O controller.
package io_pkg;

  localparam logic [31:0] IN_BASE = 32'hFFFF_FC00;
  localparam logic [31:0] TEST    = 32'hFFFF_FC20;
  localparam logic [31:0] SEG     = 32'hFFFF_FC24;
  localparam logic [31:0] LED     = 32'hFFFF_FC28;
  localparam logic [31:0] BLINK   = 32'hFFFF_FC2C;
  localparam logic [31:0] DWELL   = 32'hFFFF_FC30;
  localparam logic [31:0] STATUS  = 32'hFFFF_FC34;
  localparam logic [31:0] SKIP    = 32'hFFFF_FC38;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } disp_state_t;

  // A zero dwell would underflow the counter reload, so it is treated as 1.
  function automatic logic [31:0] dwell_clamp(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/io_seg_queue.sv
// Seven-segment value queue: FIFO feeding a two-state display FSM that holds
// each dequeued value for a programmable number of cycles.
module io_seg_queue
  import io_pkg::*;
#(
  parameter int SEG_W      = 24,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [SEG_W-1:0]              data,
  input  logic [31:0]                   dwell,
  input  logic                          skip,
  input  logic                          ovf_clr,
  output logic [SEG_W-1:0]              seg_out,
  output logic                          seg_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [SEG_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [31:0]      dwell_cnt;
  disp_state_t      state;
  disp_state_t      state_next;
  logic             pop;
  logic             expire;
  logic             push_ok;
  logic             ovf_set;

  assign count   = cnt;
  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(FIFO_DEPTH));
  assign expire  = (dwell_cnt == 32'd0) || skip;
  // A full queue still accepts a push when the display pops in the same cycle.
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = SHOW;
        end
      end
      SHOW: begin
        if (expire) begin
          if (!empty) pop = 1'b1;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push_ok) - CW'(pop);
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Display register: the counter holds remaining cycles minus one.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out   <= '0;
      seg_valid <= 1'b0;
      dwell_cnt <= 32'd0;
    end else if (pop) begin
      seg_out   <= mem[rd_ptr];
      seg_valid <= 1'b1;
      dwell_cnt <= dwell - 32'd1;
    end else if (state == SHOW) begin
      if (expire) seg_valid <= 1'b0;
      else        dwell_cnt <= dwell_cnt - 32'd1;
    end
  end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller: switch latches, read-back mux, LED, blink timer
// and queued seven-segment display. Define IO_SEG_SKIP_EN to map the SKIP register.
module mmio_io_ctrl
  import io_pkg::*;
#(
  parameter int N_IN       = 2,
  parameter int IN_W       = 8,
  parameter int TEST_W     = 3,
  parameter int SEG_W      = 24,
  parameter int FIFO_DEPTH = 32,
  parameter int DWELL_RST  = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_read,
  input  logic              io_write,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       rdata,
  input  logic [IN_W-1:0]   sw_in,
  input  logic [N_IN-1:0]   enter,
  input  logic [TEST_W-1:0] test_in,
  output logic [SEG_W-1:0]  seg_out,
  output logic              seg_valid,
  output logic [23:0]       led_out,
  output logic              blink_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [IN_W-1:0] in_reg [N_IN];
  logic [31:0]     dwell_reg;
  logic [31:0]     blink_cnt;
  logic [31:0]     blink_next;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            overflow;
  logic [31:0]     status_word;
  logic            wr_seg;
  logic            wr_led;
  logic            wr_blink;
  logic            wr_dwell;
  logic            wr_status;
  logic            skip;

  assign wr_seg    = io_write && (addr == SEG);
  assign wr_led    = io_write && (addr == LED);
  assign wr_blink  = io_write && (addr == BLINK);
  assign wr_dwell  = io_write && (addr == DWELL);
  assign wr_status = io_write && (addr == STATUS);

`ifdef IO_SEG_SKIP_EN
  assign skip = io_write && (addr == SKIP);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) in_reg[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (enter[i]) in_reg[i] <= sw_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_out   <= 24'd0;
      dwell_reg <= 32'(DWELL_RST);
    end else begin
      if (wr_led)   led_out   <= wdata[23:0];
      if (wr_dwell) dwell_reg <= dwell_clamp(wdata);
    end
  end

  // Blink output is registered from the post-update counter value.
  always_comb begin
    blink_next = blink_cnt;
    if (wr_blink)               blink_next = wdata;
    else if (blink_cnt != 32'd0) blink_next = blink_cnt - 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= 32'd0;
      blink_out <= 1'b0;
    end else begin
      blink_cnt <= blink_next;
      blink_out <= (blink_next != 32'd0);
    end
  end

  always_comb begin
    status_word                    = 32'd0;
    status_word[ST_CNT_LSB +: 16]  = 16'(count);
    status_word[ST_OVF]            = overflow;
    status_word[ST_FULL]           = full;
    status_word[ST_EMPTY]          = empty;
  end

  always_comb begin
    rdata = mem_rdata;
    if (io_read) begin
      for (int i = 0; i < N_IN; i++) begin
        if (addr == IN_BASE + 32'(4 * i)) rdata = 32'(in_reg[i]);
      end
      if (addr == TEST)   rdata = 32'(test_in);
      if (addr == STATUS) rdata = status_word;
    end
  end

  io_seg_queue #(
    .SEG_W      (SEG_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_seg_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_seg),
    .data      (wdata[SEG_W-1:0]),
    .dwell     (dwell_reg),
    .skip      (skip),
    .ovf_clr   (wr_status),
    .seg_out   (seg_out),
    .seg_valid (seg_valid),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
- Parametrised memory-mapped I/O controller between the CPU datapath (ALU address, store data, memory read data) and board peripherals.
- Provides N_IN latched switch input channels, a read-back mux, an LED register and a blink timer.
- Provides a FIFO-queued seven-segment value stream; each queued value is displayed for a programmable dwell time.
- Replaces the fixed two-input, fixed-depth I/O block. Adds reset, a status register, an overflow flag and a runtime-programmable dwell time.

Parameters:
- N_IN, 2, number of latched switch input channels (1..8)
- IN_W, 8, width of each switch input channel
- TEST_W, 3, width of the test input
- SEG_W, 24, width of a display value
- FIFO_DEPTH, 32, display queue depth; power of two, at least 2
- DWELL_RST, 100_000_000, dwell-time reset value in cycles; must be at least 1

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- io_read  in  1  CPU I/O load strobe
- io_write  in  1  CPU I/O store strobe, one cycle per store
- addr  in  32  ALU result / effective address
- wdata  in  32  store data (read_data_2)
- mem_rdata  in  32  data-memory read data
- rdata  out  32  memory-or-I/O result to writeback
- sw_in  in  IN_W  board switches
- enter  in  N_IN  per-channel latch buttons, level-sensitive
- test_in  in  TEST_W  test-case selector switches
- seg_out  out  SEG_W  value currently on display
- seg_valid  out  1  display currently holding a dequeued value
- led_out  out  24  LED register
- blink_out  out  1  high while the blink timer is nonzero

Behaviour:
- Reset values:
  - in_reg[*]=0, led_out=0, seg_out=0, seg_valid=0, blink_out=0.
  - FIFO empty, overflow=0, dwell counter=0, dwell register=DWELL_RST.
- Address map (word addresses, exact match on all 32 bits):
  - IN_BASE+4*i: input channel i.
  - TEST, SEG, LED, BLINK, DWELL, STATUS: fixed addresses.
  - Unmapped I/O addresses: reads return mem_rdata; writes are ignored.
- Input latch: each cycle enter[i]=1, in_reg[i]<=sw_in. Multiple enters asserted together all latch the same value.
- rdata is combinational. When io_read=1:
  - IN_BASE+4*i returns zero-extended in_reg[i].
  - TEST returns zero-extended test_in.
  - STATUS returns {count[31:16], 13'b0, overflow, full, empty}.
  - All other addresses, and io_read=0, return mem_rdata.
- Writes act on the posedge where io_write=1:
  - LED: led_out<=wdata[23:0].
  - BLINK: blink counter<=wdata.
  - DWELL: dwell register<=max(wdata,1); takes effect on the next dequeue.
  - STATUS: clears overflow.
- Blink timer:
  - Decrements by 1 per cycle while nonzero; blink_out = (counter != 0), registered.
  - A write while counting reloads the counter. Writing 0 stops it; blink_out is low the next cycle.
- Segment FIFO:
  - A write to SEG pushes wdata[SEG_W-1:0].
  - Push while full: data dropped, overflow<=1 (sticky).
  - Push and pop in the same cycle while full: push accepted, count unchanged.
  - Push and pop in the same cycle while empty: pop sees empty; push lands.
  - Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- Display FSM, states IDLE and SHOW:
  - IDLE -> SHOW when FIFO is non-empty: pop head to seg_out, dwell counter<=dwell register-1, seg_valid<=1. First display appears 1 cycle after the push is visible.
  - SHOW: decrement the dwell counter. At 0, if FIFO is non-empty, pop the next value and reload the counter (back-to-back, no gap). Otherwise go to IDLE with seg_valid<=0; seg_out holds its last value.
- rst mid-operation: FIFO flushed, FSM to IDLE, blink stopped. No partial state survives.

Optional Feature:
- Macro: IO_SEG_SKIP_EN.
- When defined: a write to address SKIP while in SHOW forces dwell expiry in that cycle, with the normal expiry behaviour (pop next or go to IDLE). Ignored in IDLE.
- When undefined: SKIP is unmapped and writes to it are ignored.

Decomposition:
- Package io_pkg holds:
  - address constants IN_BASE, TEST, SEG, LED, BLINK, DWELL, STATUS, SKIP;
  - STATUS bit positions;
  - display FSM state enum {IDLE, SHOW}.
- Sub-module io_seg_queue contains the FIFO, display FSM and dwell counter. Its ports: push and data, dwell value, skip, seg_out, seg_valid, count, full, empty, overflow-clear.
- The top level holds address decode, input latches, LED, blink and the read mux.

Test Plan:
1. Reset, then sw_in=0x5A with enter[0] pulsed, then sw_in=0x3C with enter[1] pulsed; read IN_BASE and IN_BASE+4 -> rdata 0x5A and 0x3C. Read an unmapped address with mem_rdata=0xDEADBEEF -> 0xDEADBEEF.
2. Write DWELL=4; push 0x000111, 0x000222 -> seg_out shows 0x000111 for exactly 4 cycles, then 0x000222 for 4 cycles with no gap, then seg_valid=0 and seg_out stays 0x000222.
3. With DWELL=1000, push 33 values into FIFO_DEPTH=32 before any expiry -> first value goes to display; the remaining 32 fill the FIFO. STATUS full=1, count=32, overflow=0. A 34th push sets overflow=1. Write STATUS -> overflow=0.
4. Write BLINK=3 -> blink_out high exactly 3 cycles. Write BLINK=10, then BLINK=0 after 2 cycles -> blink_out low on the following cycle.
5. Assert rst while in SHOW with 5 entries queued -> next cycle empty=1, count=0, seg_valid=0, blink_out=0, led_out=0.
6. With IO_SEG_SKIP_EN defined, DWELL=100, two values pushed: write SKIP 10 cycles into the first -> the second value is displayed the next cycle. With the macro undefined -> the first value is held the full 100 cycles.
